// File: rtl/button_debounce_bank.sv
// -----------------------------------------------------------------------------
// button_debounce_bank
//
// N-channel push-button conditioner. Each channel contains:
//   - a 2-FF synchroniser,
//   - a debounce filter,
//   - press/release edge pulses,
//   - a toggle bit.
// Every output is a register clocked by clk. No logic is clocked from a
// filtered signal.
//
// Optional feature: define BTN_LONG_PRESS_EN to build the long-press
// detector. Without it, long_press is tied low and the port list is the same.
//
// Ports:
//   clk        in   1     system clock
//   reset      in   1     asynchronous, active-high reset
//   btn_in     in   N_CH  raw button inputs (pressed = 1), asynchronous
//   level      out  N_CH  debounced button level
//   press      out  N_CH  1-cycle pulse on accepted 0->1
//   release_p  out  N_CH  1-cycle pulse on accepted 1->0
//   toggle     out  N_CH  flips on every accepted press
//   long_press out  N_CH  1-cycle pulse once a press has been held LONG_CYCLES
// -----------------------------------------------------------------------------
module button_debounce_bank #(
  parameter int unsigned N_CH            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1500000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter logic        TOGGLE_INIT     = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] toggle,
  output logic [N_CH-1:0] long_press
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]  sync1_q;
  logic [N_CH-1:0]  sync2_q;
  logic [N_CH-1:0]  level_q;
  logic [N_CH-1:0]  level_d;
  logic [N_CH-1:0]  press_q;
  logic [N_CH-1:0]  press_d;
  logic [N_CH-1:0]  release_q;
  logic [N_CH-1:0]  release_d;
  logic [N_CH-1:0]  toggle_q;
  logic [N_CH-1:0]  toggle_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // Debounce next-state: count consecutive cycles where the synchronised
  // input disagrees with the accepted level; accept on the last one.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_d[i]     = cnt_q[i];
      level_d[i]   = level_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      toggle_d[i]  = toggle_q[i];
      if (sync2_q[i] == level_q[i]) begin
        // Agreement (or a bounce back) discards any partial count.
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        // Accepting clears the counter, so it never exceeds CNT_LAST.
        cnt_d[i]     = {CNT_W{1'b0}};
        level_d[i]   = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
        if (sync2_q[i]) begin
          toggle_d[i] = ~toggle_q[i];
        end else begin
          toggle_d[i] = toggle_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Synchroniser, debounce counters and the registered level/event outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= {N_CH{1'b0}};
      sync2_q   <= {N_CH{1'b0}};
      level_q   <= {N_CH{1'b0}};
      press_q   <= {N_CH{1'b0}};
      release_q <= {N_CH{1'b0}};
      toggle_q  <= {N_CH{TOGGLE_INIT}};
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_p = release_q;
  assign toggle    = toggle_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned       LCNT_W   = $clog2(LONG_CYCLES + 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LONG_CYCLES);

  logic [LCNT_W-1:0] lcnt_q [N_CH];
  logic [LCNT_W-1:0] lcnt_d [N_CH];
  logic [N_CH-1:0]   long_q;
  logic [N_CH-1:0]   long_d;

  // Long-press next-state: count held cycles, saturate at LCNT_MAX. The
  // pulse fires only on the step into saturation, so it cannot repeat.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      lcnt_d[i] = lcnt_q[i];
      long_d[i] = 1'b0;
      if (!level_q[i]) begin
        lcnt_d[i] = {LCNT_W{1'b0}};
      end else if (lcnt_q[i] != LCNT_MAX) begin
        lcnt_d[i] = lcnt_q[i] + LCNT_W'(1);
        long_d[i] = (lcnt_q[i] == (LCNT_MAX - LCNT_W'(1)));
      end else begin
        lcnt_d[i] = lcnt_q[i];
      end
    end
  end

  // Long-press counters and the registered pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_q <= {N_CH{1'b0}};
      for (int i = 0; i < int'(N_CH); i++) begin
        lcnt_q[i] <= {LCNT_W{1'b0}};
      end
    end else begin
      long_q <= long_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        lcnt_q[i] <= lcnt_d[i];
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = {N_CH{1'b0}};
`endif

endmodule

// File: tb/tb_button_debounce_bank.sv
// -----------------------------------------------------------------------------
// Testbench for button_debounce_bank (N_CH=3, DEBOUNCE_CYCLES=8,
// LONG_CYCLES=20).
//
// Reference model: each channel keeps a window of the last DEBOUNCE_CYCLES
// synchronised samples. A change is accepted when the whole window disagrees
// with the current level. Long press is a count of held cycles.
//
// The model pushes one expected record per clock edge. A monitor pops one
// record per falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_button_debounce_bank;

  localparam int N_CH = 3;
  localparam int DEB  = 8;
  localparam int LNG  = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_p;
  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] long_press;

  button_debounce_bank #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .TOGGLE_INIT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .level(level), .press(press),
    .release_p(release_p), .toggle(toggle), .long_press(long_press)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0] lvl;
    logic [N_CH-1:0] prs;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] tog;
    logic [N_CH-1:0] lp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference-model state.
  logic [N_CH-1:0] m_level;
  logic [N_CH-1:0] m_tog;
  logic [N_CH-1:0] m_p0;   // btn_in sampled one edge ago
  logic [N_CH-1:0] m_p1;   // btn_in sampled two edges ago (what the filter sees)
  logic [DEB-1:0]  m_win [N_CH];
  int              m_fill [N_CH];
  int              m_held [N_CH];

  task automatic model_step();
    exp_t            e;
    logic [N_CH-1:0] s;
    e = '0;
    if (reset) begin
      m_level = '0;
      m_tog   = '0;
      m_p0    = '0;
      m_p1    = '0;
      for (int c = 0; c < N_CH; c++) begin
        m_win[c]  = '0;
        m_fill[c] = 0;
        m_held[c] = 0;
      end
    end else begin
      s = m_p1;
      for (int c = 0; c < N_CH; c++) begin
        // Long press: cycles already spent at level 1 before this edge.
        if (m_level[c]) begin
          if (m_held[c] < LNG) begin
            m_held[c]++;
`ifdef BTN_LONG_PRESS_EN
            if (m_held[c] == LNG) e.lp[c] = 1'b1;
`endif
          end
        end else begin
          m_held[c] = 0;
        end
        // Debounce: accept once DEB consecutive samples all disagree.
        m_win[c] = {m_win[c][DEB-2:0], s[c]};
        if (m_fill[c] < DEB) m_fill[c]++;
        if (m_fill[c] == DEB && m_win[c] == {DEB{~m_level[c]}}) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) begin
            e.prs[c] = 1'b1;
            m_tog[c] = ~m_tog[c];
          end else begin
            e.rel[c] = 1'b1;
          end
        end
      end
      m_p1 = m_p0;
      m_p0 = btn_in;
    end
    e.lvl = m_level;
    e.tog = m_tog;
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic cmp(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Scoreboard monitor: compares one expected record per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("level", level, e.lvl);
        cmp("press", press, e.prs);
        cmp("release_p", release_p, e.rel);
        cmp("toggle", toggle, e.tog);
        cmp("long_press", long_press, e.lp);
        if (press & release_p) begin
          n_err++;
          $display("FAIL press_release_overlap at %0t: press %b release_p %b", $time, press, release_p);
        end
      end
    end
  end

  task automatic hold(input logic [N_CH-1:0] b, input int n);
    btn_in = b;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    hold(3'b000, 50);                       // idle after reset
    hold(3'b001, 14);                       // ch0 step and hold
    hold(3'b011, 7);                        // ch1 glitch train
    hold(3'b001, 1);
    hold(3'b011, 7);
    hold(3'b001, 1);
    hold(3'b011, 14);                       // ch1 final accepted hold
    hold(3'b000, 15);
    for (int k = 0; k < 2; k++) begin       // all channels together
      hold(3'b111, 14);
      hold(3'b000, 14);
    end
    hold(3'b100, 6);                        // reset 4 cycles into ch2 debounce
    reset = 1'b1;
    hold(3'b100, 2);
    reset = 1'b0;
    hold(3'b100, 14);
    hold(3'b000, 14);
    hold(3'b001, 10 + 40);                  // long hold
    hold(3'b000, 14);
    hold(3'b001, 10 + 15);                  // release before threshold
    hold(3'b000, 14);
    for (int k = 0; k < 80; k++) begin      // randomized bounce patterns
      hold(N_CH'($urandom), $urandom_range(1, 14));
    end
    hold(3'b000, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
